cache_fill_fsm: RTL

Miss-handling controller for the direct-mapped cache, directly downstream of the hit/miss detector. It takes a miss indication and address, reads the full 16-byte block (8 words) from the multi-cycle main memory, and streams each returned word into the cache data array. On the last word it writes the tag/valid metadata. It holds the pipeline stall asserted for the whole fill.

---
 rtl/cache_fill_fsm.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one 8-word block from main memory and writes it into the data and tag arrays.
// Optional build macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN (fill starts at the missing word and wraps within the block).
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        write_data_array,
  output logic [2:0]  data_word_sel,
  output logic [15:0] fill_data,
  output logic        write_tag_array,
  output logic        fill_done
);

  if (WORDS_PER_BLOCK != 8) begin : g_bad_words
    $error("cache_fill_fsm supports only WORDS_PER_BLOCK == 8");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("cache_fill_fsm: MEM_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic [2:0]  issue_word_s;
  logic [2:0]  recv_word_s;
  logic        unused_s;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [2:0]  start_q, start_d;

  // 3-bit adds wrap naturally, keeping the fill inside the aligned block.
  assign issue_word_s = start_q + issue_cnt_q[2:0];
  assign recv_word_s  = start_q + recv_cnt_q;
  assign unused_s     = ^{miss_address[0]};

  // Critical-word start offset register.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 3'd0;
    end else begin
      start_q <= start_d;
    end
  end

  // Latch the start word only when a fill is accepted.
  always_comb begin
    start_d = start_q;
    if ((state_q == IDLE) && miss_detected) begin
      start_d = miss_address[3:1];
    end else begin
      start_d = start_q;
    end
  end
`else
  assign issue_word_s = issue_cnt_q[2:0];
  assign recv_word_s  = recv_cnt_q;
  assign unused_s     = ^{miss_address[3:0]};
`endif

  assign fill_data = memory_data;

  // State, block base and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= 16'h0000;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    data_word_sel    = 3'd0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          base_d      = {miss_address[15:4], 4'b0000};
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < 4'd8) begin
          memory_read    = 1'b1;
          memory_address = base_q + {12'h000, issue_word_s, 1'b0};
          issue_cnt_d    = issue_cnt_q + 4'd1;
        end else begin
          memory_read = 1'b0;
        end
        // Completion is driven purely by returned words, so gaps are harmless.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_sel    = recv_word_s;
          recv_cnt_d       = recv_cnt_q + 3'd1;
          if (recv_cnt_q == 3'd7) begin
            write_tag_array = 1'b1;
            state_d         = DONE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end

      DONE: begin
        fill_done = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
